// File: rtl/redstone_pkg.sv
// redstone_pkg: shared redstone signal types, strength constants and the repeater delay clamp.
package redstone_pkg;
    typedef logic [3:0] redstone;
    localparam redstone REDSTONE_MAX = 4'd15;
    localparam redstone REDSTONE_OFF = 4'd0;
    typedef enum logic [1:0] {OFF, RISE, ON, FALL} rep_state_e;
    function automatic int clamp_delay(input int sel, input int max_delay);
        return sel < 1 ? 1 : (sel > max_delay ? max_delay : sel);
    endfunction
endpackage

// File: rtl/repeater_channel.sv
// repeater_channel: one redstone repeater with programmable delay, pulse extension and side-lock.
module repeater_channel
    import redstone_pkg::*;
#(
    parameter int MAX_DELAY = 4,
    parameter int DW = $clog2(MAX_DELAY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  redstone       in,
    input  redstone       lock,
    input  logic [DW-1:0] delay_sel,
    output redstone       out,
    output logic          busy
);
    rep_state_e state;
    logic p_q;
    logic [DW-1:0] cnt, d, dec;
    assign dec = DW'(clamp_delay(int'(delay_sel), MAX_DELAY));
    assign out = (state == ON || state == FALL) ? REDSTONE_MAX : REDSTONE_OFF;
    assign busy = state == RISE || state == FALL;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            cnt <= '0;
            d <= DW'(1);
            p_q <= 1'b0;
        end else begin
            p_q <= in != '0;
            if (lock == '0) begin
                case (state)
                    OFF: if (p_q) begin
                        d <= dec;
                        cnt <= DW'(1);
                        state <= dec == DW'(1) ? ON : RISE;
                    end
                    RISE: if (cnt + 1'b1 == d) begin
                        state <= ON;
                        cnt <= DW'(1);
                    end else cnt <= cnt + 1'b1;
                    // FALL alone spans d-1 ticks, so one ON tick already yields a d-tick pulse
                    ON: if (!p_q) begin
                        if (dec == DW'(1)) state <= OFF;
                        else begin
                            state <= FALL;
                            cnt <= DW'(1);
                            d <= dec;
                        end
                    end else if (cnt < d) cnt <= cnt + 1'b1;
                    FALL: if (p_q) begin
                        state <= ON;
                        cnt <= d;
                    end else if (cnt + 1'b1 == d) state <= OFF;
                    else cnt <= cnt + 1'b1;
                endcase
            end
        end
    end
endmodule

// File: rtl/repeater_array.sv
// repeater_array: NCH independent clocked redstone repeaters, one clk edge per redstone tick.
module repeater_array
    import redstone_pkg::*;
#(
    parameter int NCH = 4,
    parameter int MAX_DELAY = 4,
    parameter int DW = $clog2(MAX_DELAY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  redstone [NCH-1:0]      in,
    input  redstone [NCH-1:0]      lock,
    input  logic [NCH-1:0][DW-1:0] delay_sel,
    output redstone [NCH-1:0]      out,
    output logic [NCH-1:0]         busy
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        repeater_channel #(.MAX_DELAY(MAX_DELAY), .DW(DW)) u_ch (
            .clk(clk),
            .rst(rst),
            .in(in[i]),
            .lock(lock[i]),
            .delay_sel(delay_sel[i]),
            .out(out[i]),
            .busy(busy[i])
        );
    end
endmodule

// File: tb/tb_repeater_array.sv
// tb_repeater_array: directed vector table plus hand-written lock, glitch and reset sequences.
module tb_repeater_array;
    import redstone_pkg::*;
    localparam int NCH = 4;
    localparam int MAX_DELAY = 4;
    localparam int DW = $clog2(MAX_DELAY + 1);

    typedef struct {
        logic [DW-1:0] dsel;
        int len;
        int rise;
        int width;
        int busy_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    redstone [NCH-1:0] din, lock, dout;
    logic [NCH-1:0][DW-1:0] dsel;
    logic [NCH-1:0] busy;
    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    repeater_array #(.NCH(NCH), .MAX_DELAY(MAX_DELAY)) dut (
        .clk(clk),
        .rst(rst),
        .in(din),
        .lock(lock),
        .delay_sel(dsel),
        .out(dout),
        .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first, last, hi, bn, bad, drops;
        vecs[0] = '{3'd1, 8, 1, 8, 0};
        vecs[1] = '{3'd2, 8, 2, 8, 2};
        vecs[2] = '{3'd3, 8, 3, 8, 4};
        vecs[3] = '{3'd4, 8, 4, 8, 6};
        vecs[4] = '{3'd0, 8, 1, 8, 0};
        vecs[5] = '{3'd7, 8, 4, 8, 6};
        vecs[6] = '{3'd3, 1, 3, 3, 4};
        vecs[7] = '{3'd3, 2, 3, 3, 4};
        vecs[8] = '{3'd2, 1, 2, 2, 2};
        vecs[9] = '{3'd4, 1, 4, 4, 6};
        rst = 1'b1;
        din = '0;
        lock = '0;
        dsel = '0;
        tick();
        tick();
        check("reset out", int'(dout), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("idle out k%0d", k), int'(dout), 0);
            check($sformatf("idle busy k%0d", k), int'(busy), 0);
        end

        for (int v = 0; v < 10; v++) begin
            dsel[0] = vecs[v].dsel;
            din[0] = 4'd8;
            first = -1;
            last = -1;
            hi = 0;
            bn = 0;
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                tick();
                if (dout[0] == REDSTONE_MAX) begin
                    if (first < 0) first = k;
                    last = k;
                    hi++;
                end else if (dout[0] != REDSTONE_OFF) bad++;
                if (busy[0]) bn++;
                if (k == vecs[v].len - 1) din[0] = '0;
            end
            check($sformatf("vec%0d rise", v), first, vecs[v].rise);
            check($sformatf("vec%0d width", v), hi, vecs[v].width);
            check($sformatf("vec%0d last", v), last, vecs[v].rise + vecs[v].width - 1);
            check($sformatf("vec%0d busy", v), bn, vecs[v].busy_n);
            check($sformatf("vec%0d level", v), bad, 0);
        end

        dsel[0] = 3'd3;
        din[0] = 4'd15;
        repeat (8) tick();
        check("glitch steady", int'(dout[0]), 15);
        din[0] = '0;
        drops = 0;
        bn = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (dout[0] != REDSTONE_MAX) drops++;
            if (busy[0]) bn++;
            din[0] = 4'd15;
        end
        check("glitch drops", drops, 0);
        check("glitch busy", bn, 1);
        din[0] = '0;
        repeat (8) tick();
        check("glitch off", int'(dout[0]), 0);

        dsel[0] = 3'd2;
        din[0] = 4'd15;
        tick();
        tick();
        check("lock pre out", int'(dout[0]), 0);
        check("lock pre busy", int'(busy[0]), 1);
        lock[0] = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("lock rise out i%0d", i), int'(dout[0]), 0);
            check($sformatf("lock rise busy i%0d", i), int'(busy[0]), 1);
            din[0] = (i == 0 || i == 2) ? 4'd0 : 4'd15;
        end
        lock[0] = '0;
        tick();
        check("lock release out", int'(dout[0]), 15);
        check("lock release busy", int'(busy[0]), 0);
        lock[0] = 4'd3;
        din[0] = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("lock on out i%0d", i), int'(dout[0]), 15);
            check($sformatf("lock on busy i%0d", i), int'(busy[0]), 0);
        end
        lock[0] = '0;
        tick();
        check("unlock fall out", int'(dout[0]), 15);
        check("unlock fall busy", int'(busy[0]), 1);
        tick();
        check("unlock off out", int'(dout[0]), 0);
        check("unlock off busy", int'(busy[0]), 0);

        dsel = {3'd4, 3'd3, 3'd2, 3'd1};
        repeat (4) tick();
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < NCH; c++) if (c == k) din[c] = 4'd15;
            tick();
            for (int c = 0; c < NCH; c++)
                check($sformatf("indep ch%0d k%0d", c, k), int'(dout[c]), k >= 2 * c + 1 ? 15 : 0);
        end

        din = '0;
        repeat (8) tick();
        check("all off", int'(dout), 0);
        din[0] = 4'd15;
        din[2] = 4'd15;
        tick();
        tick();
        check("pre-rst ch0 out", int'(dout[0]), 15);
        check("pre-rst ch2 busy", int'(busy[2]), 1);
        rst = 1'b1;
        tick();
        check("mid rst out", int'(dout), 0);
        check("mid rst busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        check("post rst ch0 e3", int'(dout[0]), 0);
        tick();
        check("post rst ch0 e4", int'(dout[0]), 15);
        check("post rst ch2 e4", int'(dout[2]), 0);
        tick();
        check("post rst ch2 e5", int'(dout[2]), 0);
        tick();
        check("post rst ch2 e6", int'(dout[2]), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
